pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
// - Program-counter register and instruction-fetch sequencer. Consumes the 64-bit
//   next-PC chosen by the upstream PC-select Mux (PC+4 vs branch target). Holds the
//   current PC, runs a req/ack fetch to instruction memory, and presents the
//   instruction to decode with a valid/ready handshake.
// - Supports stall (hazard unit) and redirect (taken branch) without losing or
//   duplicating instructions.
// PARAMETERS
// - ADDR_WIDTH   64   width of pc, next_pc, imem_addr
// - INSTR_WIDTH  32   width of imem_rdata, instr
// - RESET_PC     0    PC value loaded at reset
// PORTS
// - clk           in   1            single clock; all state updates on rising edge
// - rst_n         in   1            asynchronous, active-low reset
// - next_pc       in   ADDR_WIDTH   next PC from PC-select Mux; sampled on advance/redirect
// - branch_taken  in   1            redirect request; next_pc holds the target this cycle
// - stall         in   1            hazard stall; blocks advance in HOLD
// - imem_req      out  1            fetch request to instruction memory
// - imem_addr     out  ADDR_WIDTH   fetch address; equals pc whenever imem_req=1
// - imem_ack      in   1            memory response; imem_rdata valid in the same cycle
// - imem_rdata    in   INSTR_WIDTH  fetched instruction word
// - pc            out  ADDR_WIDTH   PC of instr / of the in-flight fetch
// - instr         out  INSTR_WIDTH  fetched instruction to decode
// - instr_valid   out  1            instr and pc valid for decode
// - instr_ready   in   1            decode accepts instr this cycle
// BEHAVIOUR
// - Reset (async, immediate): pc=imem_addr=RESET_PC; imem_req=0; instr=0;
//   instr_valid=0; kill=0; kill_pc=0; state=ISSUE.
// - FSM: ISSUE -> REQ -> HOLD -> ISSUE.
// - ISSUE: imem_req=0 for one cycle; next state REQ, imem_addr<=pc.
//   If branch_taken: pc<=next_pc, stay in ISSUE.
// - REQ: imem_req=1. imem_addr/pc stay stable until imem_ack is sampled high.
//   - branch_taken in REQ: kill<=1, kill_pc<=next_pc. Request is not abandoned.
//     Repeated redirects: last one wins.
//   - ack with kill=0 (and no branch_taken this cycle): instr<=imem_rdata,
//     instr_valid<=1, imem_req<=0, go HOLD.
//   - ack with kill=1 or branch_taken: discard data, instr_valid stays 0,
//     pc<=(branch_taken ? next_pc : kill_pc), kill<=0, go ISSUE.
// - HOLD: instr_valid=1; instr and pc stable.
//   - Priority 1, branch_taken: instr_valid<=0, pc<=next_pc, go ISSUE.
//     Redirect overrides stall and ready; the held instr is flushed.
//   - Priority 2, advance when instr_ready && !stall: handshake completes,
//     instr_valid<=0, pc<=next_pc, go ISSUE.
//   - Otherwise hold unchanged.
// - Latency: advance to next imem_req=1 is 2 cycles. ack to instr_valid=1 is 1 cycle.
//   Minimum throughput: 1 instr per 3 cycles with zero-wait memory.
// - No internal arithmetic: next_pc is taken verbatim at full ADDR_WIDTH.
// - Mid-fetch reset drops imem_req asynchronously. Any late ack after reset is
//   ignored, because the FSM is in ISSUE.
// - imem_ack outside REQ is ignored.
// CONFIGURATION
// - PC_ALIGN_CHECK_EN defined:
//   - adds output port misalign_err (1 bit, reset 0).
//   - On any load of pc from next_pc with next_pc[1:0]!=0: pc still loads, the FSM
//     enters a terminal ERR state with imem_req=0 and instr_valid=0, and
//     misalign_err<=1 (sticky until rst_n).
// - PC_ALIGN_CHECK_EN undefined: no port, no ERR state; misaligned next_pc is
//   fetched as-is.
// TESTING
// - Reset, zero-wait memory, ready=1, next_pc=pc+4:
//   -> imem_addr sequence 0x0, 0x4, 0x8. instr_valid pulses once per 3 cycles;
//      pc matches each instr.
// - imem_ack delayed 4 cycles:
//   -> imem_req and imem_addr=0x4 held steady for all 4 cycles; one instr delivered.
// - HOLD with instr_ready=0 or stall=1 for 5 cycles:
//   -> instr, pc and instr_valid unchanged; advance on the first cycle with
//      ready=1 and stall=0.
// - branch_taken with next_pc=0x100 during REQ for 0x8:
//   -> ack for 0x8 discarded with no instr_valid; next imem_addr=0x100.
// - branch_taken with next_pc=0x200 in HOLD with stall=1:
//   -> instr flushed; next fetch at 0x200.
// - Under PC_ALIGN_CHECK_EN, next_pc=0x102 on advance:
//   -> misalign_err=1, imem_req stays 0; rst_n low clears it.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// pc_fetch_ctrl : PC register + req/ack fetch sequencer (ISSUE->REQ->HOLD);
//                 optional misaligned-PC trap via `PC_ALIGN_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module pc_fetch_ctrl #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef PC_ALIGN_CHECK_EN
    output logic                   misalign_err,
`endif
    input  logic [ADDR_WIDTH-1:0]  next_pc,
    input  logic                   branch_taken,
    input  logic                   stall,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready
);

    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [1:0] S_ERR   = 2'd3;
`endif

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  imem_addr_q, imem_addr_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   kill_q, kill_d;
    logic [ADDR_WIDTH-1:0]  kill_pc_q, kill_pc_d;
    logic                   w_pc_from_next;
`ifdef PC_ALIGN_CHECK_EN
    logic                   misalign_err_q, misalign_err_d;
`endif

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        imem_addr_d    = imem_addr_q;
        instr_d        = instr_q;
        instr_valid_d  = instr_valid_q;
        kill_d         = kill_q;
        kill_pc_d      = kill_pc_q;
        w_pc_from_next = 1'b0;
        case (state_q)
            S_ISSUE: begin
                if (branch_taken) begin
                    pc_d           = next_pc;
                    w_pc_from_next = 1'b1;
                end else begin
                    state_d     = S_REQ;
                    imem_addr_d = pc_q;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (kill_q || branch_taken) begin
                        // Redirected fetch: drop the returned word, refetch at the target.
                        pc_d           = branch_taken ? next_pc : kill_pc_q;
                        w_pc_from_next = branch_taken;
                        kill_d         = 1'b0;
                        state_d        = S_ISSUE;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (branch_taken) begin
                    kill_d    = 1'b1;
                    kill_pc_d = next_pc;
                end
            end
            S_HOLD: begin
                if (branch_taken || (instr_ready && !stall)) begin
                    instr_valid_d  = 1'b0;
                    pc_d           = next_pc;
                    w_pc_from_next = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
`ifdef PC_ALIGN_CHECK_EN
            S_ERR: begin
            end
`endif
            default: state_d = S_ISSUE;
        endcase
`ifdef PC_ALIGN_CHECK_EN
        misalign_err_d = misalign_err_q;
        if (w_pc_from_next && (next_pc[1:0] != 2'b00)) begin
            state_d        = S_ERR;
            instr_valid_d  = 1'b0;
            misalign_err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_ISSUE;
            pc_q          <= RESET_PC;
            imem_addr_q   <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            kill_q        <= 1'b0;
            kill_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            kill_q        <= kill_d;
            kill_pc_q     <= kill_pc_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_err_q <= 1'b0;
        else        misalign_err_q <= misalign_err_d;
    end
    assign misalign_err = misalign_err_q;
`endif

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = imem_addr_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;

endmodule

`default_nettype wire
